// File: rtl/alien_pkg.sv
// rtl/alien_pkg.sv - formation states, default geometry and index widths
package alien_pkg;

  typedef enum logic [1:0] {
    MARCH   = 2'd0,
    DESCEND = 2'd1,
    CLEAR   = 2'd2,
    INVADED = 2'd3
  } state_t;

  localparam int ROWS        = 5;
  localparam int COLS        = 11;
  localparam int CELL_W      = 32;
  localparam int CELL_H      = 24;
  localparam int ALIEN_W     = 25;
  localparam int ALIEN_H     = 20;
  localparam int X0          = 32;
  localparam int Y0          = 40;
  localparam int X_MIN       = 0;
  localparam int X_MAX       = 639;
  localparam int Y_LIMIT     = 440;
  localparam int STEP_X      = 2;
  localparam int DROP_Y      = 16;
  localparam int SPEED_SHIFT = 2;
  localparam int MIN_PERIOD  = 1;

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);

endpackage

// File: rtl/alien_formation_if.sv
// rtl/alien_formation_if.sv - control/hit inputs and formation state outputs
interface alien_formation_if
  import alien_pkg::*;
#(
  parameter int ROWS = alien_pkg::ROWS,
  parameter int COLS = alien_pkg::COLS
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic                 enable;
  logic                 hit_valid;
  logic [RW-1:0]        hit_row;
  logic [CW-1:0]        hit_col;
  logic [9:0]           origin_x;
  logic [9:0]           origin_y;
  logic [ROWS*COLS-1:0] alive;
  logic [7:0]           alive_count;
  logic                 dir_right;
  logic                 step_pulse;
  logic                 wave_clear;
  logic                 invaded;

  modport master (
    output enable, hit_valid, hit_row, hit_col,
    input  origin_x, origin_y, alive, alive_count, dir_right,
    input  step_pulse, wave_clear, invaded
  );

  modport slave (
    input  enable, hit_valid, hit_row, hit_col,
    output origin_x, origin_y, alive, alive_count, dir_right,
    output step_pulse, wave_clear, invaded
  );

endinterface

// File: rtl/alien_extent.sv
// rtl/alien_extent.sv - leftmost/rightmost live column and lowest live row of the mask
module alien_extent
  import alien_pkg::*;
#(
  parameter int ROWS = alien_pkg::ROWS,
  parameter int COLS = alien_pkg::COLS
) (
  input  logic [ROWS*COLS-1:0]     i_alive,
  output logic [$clog2(COLS)-1:0]  o_left,
  output logic [$clog2(COLS)-1:0]  o_right,
  output logic [$clog2(ROWS)-1:0]  o_bottom,
  output logic                     o_any
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [COLS-1:0] w_col_any;
  logic [ROWS-1:0] w_row_any;

  always_comb begin
    w_col_any = '0;
    w_row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (i_alive[r*COLS+c]) begin
          w_col_any[c] = 1'b1;
          w_row_any[r] = 1'b1;
        end
      end
    end
  end

  // Loop direction sets the priority: the last match written wins.
  always_comb begin
    o_left   = '0;
    o_right  = '0;
    o_bottom = '0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (w_col_any[c]) o_left = CW'(c);
    end
    for (int c = 0; c < COLS; c++) begin
      if (w_col_any[c]) o_right = CW'(c);
    end
    for (int r = 0; r < ROWS; r++) begin
      if (w_row_any[r]) o_bottom = RW'(r);
    end
  end

  assign o_any = |w_row_any;

endmodule

// File: rtl/alien_formation.sv
// rtl/alien_formation.sv - rigid alien formation: march, drop/reverse at edges, kill mask, speed-up
module alien_formation
  import alien_pkg::*;
#(
  parameter int ROWS        = alien_pkg::ROWS,
  parameter int COLS        = alien_pkg::COLS,
  parameter int CELL_W      = alien_pkg::CELL_W,
  parameter int CELL_H      = alien_pkg::CELL_H,
  parameter int ALIEN_W     = alien_pkg::ALIEN_W,
  parameter int ALIEN_H     = alien_pkg::ALIEN_H,
  parameter int X0          = alien_pkg::X0,
  parameter int Y0          = alien_pkg::Y0,
  parameter int X_MIN       = alien_pkg::X_MIN,
  parameter int X_MAX       = alien_pkg::X_MAX,
  parameter int Y_LIMIT     = alien_pkg::Y_LIMIT,
  parameter int STEP_X      = alien_pkg::STEP_X,
  parameter int DROP_Y      = alien_pkg::DROP_Y,
  parameter int SPEED_SHIFT = alien_pkg::SPEED_SHIFT,
  parameter int MIN_PERIOD  = alien_pkg::MIN_PERIOD
) (
  input  logic             frame_clk,
  input  logic             Reset,
  alien_formation_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  state_t          r_state;
  state_t          w_next;
  logic [N-1:0]    r_alive;
  logic [7:0]      r_count;
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic            r_dir;
  logic [7:0]      r_cnt;

  logic [CW-1:0]   w_left;
  logic [CW-1:0]   w_right;
  logic [RW-1:0]   w_bottom;
  logic            w_any;
  logic            w_active;
  logic [7:0]      w_period;
  logic            w_step;
  logic [10:0]     w_right_edge;
  logic [10:0]     w_left_edge;
  logic [10:0]     w_drop_y;
  logic            w_at_right;
  logic            w_at_left;
  logic            w_invade;
  logic [7:0]      w_hit_idx;
  logic [N-1:0]    w_hit_mask;
  logic            w_hit_in_range;
  logic            w_hit_ok;

  alien_extent #(.ROWS(ROWS), .COLS(COLS)) u_extent (
    .i_alive  (r_alive),
    .o_left   (w_left),
    .o_right  (w_right),
    .o_bottom (w_bottom),
    .o_any    (w_any)
  );

  assign w_active = (r_state == MARCH) || (r_state == DESCEND);
  assign w_period = 8'(32'(r_count >> SPEED_SHIFT) + MIN_PERIOD);
  // ">=" rather than "==" so a period that shrank under the counter still fires.
  assign w_step   = w_active && bus.enable && w_any && (r_cnt >= (w_period - 8'd1));

  assign w_right_edge = {1'b0, r_x} + 11'(w_right) * 11'(CELL_W) + 11'(ALIEN_W - 1);
  assign w_left_edge  = {1'b0, r_x} + 11'(w_left) * 11'(CELL_W);
  assign w_at_right   = (w_right_edge + 11'(STEP_X)) > 11'(X_MAX);
  assign w_at_left    = w_left_edge < 11'(X_MIN + STEP_X);
  assign w_drop_y     = {1'b0, r_y} + 11'(DROP_Y);
  assign w_invade     = (w_drop_y + 11'(w_bottom) * 11'(CELL_H) + 11'(ALIEN_H - 1)) >= 11'(Y_LIMIT);

  assign w_hit_idx      = 8'(bus.hit_row) * 8'(COLS) + 8'(bus.hit_col);
  assign w_hit_mask     = {{(N-1){1'b0}}, 1'b1} << w_hit_idx;
  assign w_hit_in_range = (32'(bus.hit_row) < ROWS) && (32'(bus.hit_col) < COLS);
  assign w_hit_ok       = bus.hit_valid && (r_state != INVADED) && w_hit_in_range
                          && |(r_alive & w_hit_mask);

  always_ff @(posedge frame_clk) begin
    if (Reset) r_state <= MARCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MARCH: begin
        if (!w_any)                                       w_next = CLEAR;
        else if (w_step && (r_dir ? w_at_right : w_at_left)) w_next = DESCEND;
      end
      DESCEND: begin
        if (!w_any)      w_next = CLEAR;
        else if (w_step) w_next = w_invade ? INVADED : MARCH;
      end
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    bus.step_pulse = w_step;
    bus.wave_clear = (r_state == CLEAR);
    bus.invaded    = (r_state == INVADED);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_x   <= 10'(X0);
      r_y   <= 10'(Y0);
      r_dir <= 1'b1;
    end else if (w_step) begin
      if (r_state == MARCH) begin
        if (r_dir && !w_at_right)      r_x <= r_x + 10'(STEP_X);
        else if (!r_dir && !w_at_left) r_x <= r_x - 10'(STEP_X);
      end else begin
        r_y   <= w_drop_y[9:0];
        r_dir <= ~r_dir;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset)                             r_cnt <= 8'd0;
    else if (w_step)                       r_cnt <= 8'd0;
    else if (w_active && bus.enable && w_any) r_cnt <= r_cnt + 8'd1;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_alive <= '1;
      r_count <= 8'(N);
    end else if (w_hit_ok) begin
      r_alive <= r_alive & ~w_hit_mask;
      r_count <= r_count - 8'd1;
    end
  end

  assign bus.origin_x    = r_x;
  assign bus.origin_y    = r_y;
  assign bus.alive       = r_alive;
  assign bus.alive_count = r_count;
  assign bus.dir_right   = r_dir;

endmodule

// File: tb/tb_alien_formation.sv
// tb/tb_alien_formation.sv - randomized and directed checks against a behavioural formation model
module tb_alien_formation;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alien_formation_if bus ();
  alien_formation dut (.frame_clk(clk), .Reset(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 march, 1 descend, 2 clear, 3 invaded.
  int          mx, my, mcount, mcnt, mstate;
  bit          mdir;
  logic [54:0] malive;
  bit          last_step;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_step(input bit en);
    int period;
    period = (mcount >> 2) + 1;
    return (mstate < 2) && en && (mcount > 0) && (mcnt >= period - 1);
  endfunction

  task automatic m_update(input bit r, input bit en, input bit hv, input int hr, input int hc);
    int L, R, B, nx, ny, ns, ncnt;
    bit nd, st;
    if (r) begin
      mx = 32; my = 40; mdir = 1; mcount = 55; mcnt = 0; mstate = 0; malive = '1;
      return;
    end
    L = 99; R = -1; B = -1;
    for (int i = 0; i < 55; i++) begin
      if (malive[i]) begin
        if (i % 11 < L) L = i % 11;
        if (i % 11 > R) R = i % 11;
        if (i / 11 > B) B = i / 11;
      end
    end
    st = m_step(en);
    nx = mx; ny = my; nd = mdir; ns = mstate; ncnt = mcnt;
    if (mstate < 2 && mcount == 0) ns = 2;
    else if (st && mstate == 0) begin
      if (mdir) begin
        if (mx + R*32 + 24 + 2 > 639) ns = 1; else nx = mx + 2;
      end else begin
        if (mx + L*32 < 2) ns = 1; else nx = mx - 2;
      end
    end else if (st && mstate == 1) begin
      ny = my + 16;
      nd = !mdir;
      ns = (ny + B*24 + 19 >= 440) ? 3 : 0;
    end
    if (st) ncnt = 0;
    else if (mstate < 2 && en && mcount > 0) ncnt = mcnt + 1;
    if (mstate != 3 && hv && hr < 5 && hc < 11 && malive[hr*11+hc]) begin
      malive[hr*11+hc] = 1'b0;
      mcount--;
    end
    mx = nx; my = ny; mdir = nd; mstate = ns; mcnt = ncnt;
  endtask

  // One frame: drive at negedge, check the step strobe, clock, then check registered outputs.
  task automatic cyc(input bit en, input bit hv, input int hr, input int hc, input bit r);
    rst           = r;
    bus.enable    = en;
    bus.hit_valid = hv;
    bus.hit_row   = 3'(hr);
    bus.hit_col   = 4'(hc);
    #1;
    last_step = bus.step_pulse;
    if (!r) chk("step_pulse", bus.step_pulse, m_step(en));
    @(posedge clk);
    m_update(r, en, hv, hr, hc);
    @(negedge clk);
    chk("origin_x", bus.origin_x, mx);
    chk("origin_y", bus.origin_y, my);
    chk("alive", bus.alive, malive);
    chk("alive_count", bus.alive_count, mcount);
    chk("dir_right", bus.dir_right, mdir);
    chk("wave_clear", bus.wave_clear, mstate == 2);
    chk("invaded", bus.invaded, mstate == 3);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic run_to_drop(input string tag, output int first, output int steps);
    int k;
    k = 0; first = 0; steps = 0;
    while (bus.origin_y == 10'd40 && k < 4000) begin
      k++;
      cyc(1, 0, 0, 0, 0);
      if (last_step) begin
        steps++;
        if (first == 0) first = k;
      end
    end
    chk({tag, "_drop_reached"}, k < 4000, 1);
  endtask

  initial begin
    int first, steps, k, descents, sx, sy;
    int order[55];
    logic [54:0] sa, exp_alive;
    bit hit_done;

    bus.enable = 0; bus.hit_valid = 0; bus.hit_row = '0; bus.hit_col = '0;
    @(negedge clk);

    // Reset values and plain march to the first descent
    do_reset();
    chk("rst_x", bus.origin_x, 32);
    chk("rst_y", bus.origin_y, 40);
    chk("rst_count", bus.alive_count, 55);
    chk("rst_dir", bus.dir_right, 1);
    chk("rst_clear", bus.wave_clear, 0);
    run_to_drop("t1", first, steps);
    chk("t1_first_step", first, 14);
    chk("t1_steps", steps, 133);
    chk("t1_x", bus.origin_x, 294);
    chk("t1_y", bus.origin_y, 56);
    chk("t1_dir", bus.dir_right, 0);

    // Column 10 killed: faster period, wider travel
    do_reset();
    for (int r = 0; r < 5; r++) cyc(0, 1, r, 10, 0);
    chk("t2_count", bus.alive_count, 50);
    run_to_drop("t2", first, steps);
    chk("t2_first_step", first, 13);
    chk("t2_steps", steps, 149);
    chk("t2_x", bus.origin_x, 326);

    // Duplicate and out-of-range hits
    do_reset();
    cyc(0, 1, 2, 3, 0);
    cyc(0, 1, 2, 3, 0);
    cyc(0, 1, 7, 0, 0);
    exp_alive = '1;
    exp_alive[25] = 1'b0;
    chk("t3_count", bus.alive_count, 54);
    chk("t3_alive", bus.alive, exp_alive);

    // Hit on the last column-10 alien in the edge step: step still descends
    do_reset();
    for (int r = 0; r < 4; r++) cyc(0, 1, r, 10, 0);
    hit_done = 0;
    for (k = 0; k < 4000 && !hit_done; k++) begin
      if (m_step(1) && mx == 294 && mstate == 0) begin
        cyc(1, 1, 4, 10, 0);
        hit_done = 1;
        chk("t4_hold_x", bus.origin_x, 294);
        chk("t4_count", bus.alive_count, 50);
      end else begin
        cyc(1, 0, 0, 0, 0);
      end
    end
    chk("t4_reached", hit_done, 1);
    run_to_drop("t4", first, steps);
    chk("t4_x", bus.origin_x, 294);
    chk("t4_y", bus.origin_y, 56);

    // Free run to invasion, then frozen
    do_reset();
    descents = 0; sy = 40; k = 0;
    while (!bus.invaded && k < 60000) begin
      k++;
      cyc(1, 0, 0, 0, 0);
      if (bus.origin_y != 10'(sy)) begin
        descents++;
        sy = bus.origin_y;
      end
    end
    chk("t5_invaded", bus.invaded, 1);
    chk("t5_descents", descents, 18);
    chk("t5_y", bus.origin_y, 328);
    sx = bus.origin_x; sa = bus.alive;
    for (int i = 0; i < 100; i++) cyc(1, 1, $urandom_range(0, 4), $urandom_range(0, 10), 0);
    chk("t5_frozen_x", bus.origin_x, sx);
    chk("t5_frozen_y", bus.origin_y, 328);
    chk("t5_frozen_alive", bus.alive, sa);

    // Random hits, enables and occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 999) == 0);

    // Kill everything in random order, then wave clear and reset
    do_reset();
    for (int i = 0; i < 55; i++) order[i] = i;
    for (int i = 54; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 55; i++) begin
      cyc(1, 1, order[i] / 11, order[i] % 11, 0);
      if ($urandom_range(0, 3) == 0) cyc(1, 1, order[i] / 11, order[i] % 11, 0);
    end
    chk("t6_count", bus.alive_count, 0);
    chk("t6_not_yet_clear", bus.wave_clear, 0);
    cyc(1, 0, 0, 0, 0);
    chk("t6_clear", bus.wave_clear, 1);
    sx = bus.origin_x; sy = bus.origin_y;
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0);
    chk("t6_frozen_x", bus.origin_x, sx);
    chk("t6_frozen_y", bus.origin_y, sy);
    cyc(1, 1, 0, 0, 1);
    chk("t6_rst_x", bus.origin_x, 32);
    chk("t6_rst_y", bus.origin_y, 40);
    chk("t6_rst_count", bus.alive_count, 55);
    chk("t6_rst_alive", bus.alive, {55{1'b1}});
    chk("t6_rst_clear", bus.wave_clear, 0);
    chk("t6_rst_invaded", bus.invaded, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
